i4001_dbg_arbiter: RTL and testbench
====================================

# i4001_dbg_arbiter

Round-robin arbiter and sequencer for the shared ROM debug/load port (dbg_addr/dbg_wdata/dbg_wen/dbg_ren/dbg_rdata) fanned out to all i4001 ROM chips.
- Serialises up to four requesters (host loader, trace unit, …) onto that single port.
- Regenerates the 8-phase instruction cycle from sync. Debug reads are held off from the A3 and M1 slots, because a read there overwrites the ROM fetch register that the chip drives on the bus in M1/M2.
- Returns read data, or an error when no ROM claims the address.

## Interface
- NUM_REQ, 2, number of requesters (1-4); index 0 has priority after reset.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sync  in  1  MCS-4 sync; the phase counter reads 0 (A1) in the cycle after sync is high.
- req_vld  in  NUM_REQ  request valid, one per requester, held until accepted.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ×12  {chip char, hi char, lo char}, same packing as dbg_addr.
- req_wdata  in  NUM_REQ×8  write byte.
- req_rdy  out  NUM_REQ  one-hot grant; the request is accepted in the cycle where req_vld & req_rdy.
- rsp_vld  out  NUM_REQ  one-cycle completion pulse to the accepted requester.
- rsp_rdata  out  8  read data, valid with rsp_vld; 0 for writes and errors.
- rsp_err  out  1  read got no dbg_rdata_vld; valid with rsp_vld.
- busy  out  1  state ≠ IDLE.
- dbg_addr  out  12  to ROMs.
- dbg_wdata  out  8  to ROMs.
- dbg_wen  out  1  to ROMs.
- dbg_ren  out  1  to ROMs.
- dbg_rdata  in  8  OR of all ROM dbg_rdata, gated by the per-chip valid.
- dbg_rdata_vld  in  1  OR of all ROM dbg_rdata_vld.

## Operation
**Phase tracker**
- A 4-bit phase counter clears on sync and increments otherwise, saturating at 15.
- phase_vld clears on reset. It sets on sync and clears when the counter reaches 15, meaning the CPU is stopped or there has been no sync for 15 cycles.
- read_ok = !phase_vld | (phase ∉ {2 (A3), 3 (M1)}). Writes are always legal because they do not touch the fetch register.

**FSM: IDLE → ISSUE → (WAIT) → RESP → IDLE**
- IDLE:
  - req_rdy is one-hot to the first requester with req_vld set, searching from (rr_ptr+1) mod NUM_REQ.
  - On acceptance, latch we/addr/wdata and the requester index; go to ISSUE.
- ISSUE, write:
  - dbg_wen=1 for exactly this cycle with the latched addr/wdata; go to RESP.
- ISSUE, read:
  - If read_ok: dbg_ren=1 for this cycle; go to WAIT.
  - Else: stay in ISSUE with dbg_ren=0. The read_ok check is repeated every cycle.
- WAIT:
  - dbg_rdata_vld=1: capture dbg_rdata, err=0.
  - dbg_rdata_vld=0: data=0, err=1 (no ROM has that chip ID).
  - Go to RESP.
- RESP:
  - rsp_vld[idx]=1, drive rsp_rdata/rsp_err; rr_ptr←idx; go to IDLE.
- dbg_addr/dbg_wdata hold the latched values from ISSUE through RESP and are 0 in IDLE.
- dbg_wen/dbg_ren are never asserted outside ISSUE and never both at once.

## Timing
- Reset (asynchronous, rst_n low):
  - All outputs 0, FSM in IDLE, rr_ptr=NUM_REQ-1, phase counter 0, phase_vld=0.
  - An in-flight request is dropped with no rsp_vld.
- Latency from acceptance to rsp_vld:
  - Write: 2 cycles.
  - Read: 3 cycles plus the stall.
  - Worst-case read stall is 2 cycles (arriving in A3).
- Throughput: one transaction per 3 (write) or 4 (read) cycles minimum, because of the IDLE turnaround.
- req_rdy is asserted only in IDLE and is combinational from req_vld and rr_ptr. No combinational path exists from dbg_rdata to any output.
- sync arriving during an ISSUE stall: the phase restarts at A1 next cycle and read_ok is re-evaluated; no special handling.
- Simultaneous req_vld on all inputs: strict rotation, so no requester waits more than NUM_REQ-1 transactions.
- Requester deasserting req_vld before acceptance: legal; it is not granted.

## Test plan
- Write then read:
  - req0: write addr 0x1_23 = 0xA5, then read it back.
  - Expect dbg_wen for one cycle with dbg_addr=0x123 and dbg_wdata=0xA5.
  - Expect the read's rsp_vld 3 cycles after acceptance with rsp_rdata=0xA5 and rsp_err=0.
- Slot guard:
  - sync running; issue a read accepted so that ISSUE lands in A3.
  - Expect dbg_ren low in A3 and M1, and high in M2.
  - A fetch of ROM 0 addr 0x10 concurrently still returns the correct M1/M2 nibbles.
- Round robin:
  - NUM_REQ=3, all req_vld held high with writes.
  - Expect the grant order 0,1,2,0,1,2.
- Missing chip:
  - Read addr 0xF_00 with no ROM ID 15 present.
  - Expect rsp_vld with rsp_err=1 and rsp_rdata=0x00.
- CPU stopped:
  - No sync for 20 cycles; issue a read in any phase.
  - Expect dbg_ren with no stall.
- Reset mid-read:
  - Drop rst_n while in WAIT.
  - Expect all outputs 0 immediately and no rsp_vld after release.
  - The next request is granted to req0.

Source files
------------

// File: rtl/i4001_dbg_arbiter.sv
// Round-robin arbiter/sequencer for the shared i4001 ROM debug port.
// Reads are held off the A3/M1 slots so the ROM fetch register is never disturbed.
module i4001_dbg_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sync,
  input  logic [NUM_REQ-1:0]       i_req_vld,
  input  logic [NUM_REQ-1:0]       i_req_we,
  input  logic [NUM_REQ-1:0][11:0] i_req_addr,
  input  logic [NUM_REQ-1:0][7:0]  i_req_wdata,
  output logic [NUM_REQ-1:0]       o_req_rdy,
  output logic [NUM_REQ-1:0]       o_rsp_vld,
  output logic [7:0]               o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic                     o_busy,
  output logic [11:0]              o_dbg_addr,
  output logic [7:0]               o_dbg_wdata,
  output logic                     o_dbg_wen,
  output logic                     o_dbg_ren,
  input  logic [7:0]               i_dbg_rdata,
  input  logic                     i_dbg_rdata_vld
);

  // state  | meaning
  // IDLE   | grant the next requester in rotation
  // ISSUE  | drive wen, or ren once the phase slot allows it
  // WAIT   | sample the ROM read data / valid
  // RESP   | pulse rsp_vld to the owner, advance rr_ptr
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_phase;
  logic              r_phase_vld;
  logic              w_read_ok;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_idx;
  logic              r_we;
  logic [11:0]       r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic              r_err;
  logic [NUM_REQ-1:0] w_grant;
  logic              w_accept;
  logic              w_sel_we;
  logic [11:0]       w_sel_addr;
  logic [7:0]        w_sel_wdata;
  logic [1:0]        w_sel_idx;

  // Phase counter saturates at 15 so a stopped CPU drops phase_vld.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase     <= 4'd0;
      r_phase_vld <= 1'b0;
    end else begin
      if (i_sync)
        r_phase <= 4'd0;
      else if (r_phase != 4'hF)
        r_phase <= r_phase + 4'd1;
      if (i_sync)
        r_phase_vld <= 1'b1;
      else if (r_phase == 4'hF)
        r_phase_vld <= 1'b0;
    end
  end

  assign w_read_ok = !r_phase_vld || ((r_phase != 4'd2) && (r_phase != 4'd3));

  always_comb begin : p_grant
    logic found;
    found   = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && i_req_vld[i] && (i == (int'(r_rr_ptr) + k) % NUM_REQ)) begin
          w_grant[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = 12'd0;
    w_sel_wdata = 8'd0;
    w_sel_idx   = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = i_req_we[i];
        w_sel_addr  = i_req_addr[i];
        w_sel_wdata = i_req_wdata[i];
        w_sel_idx   = 2'(i);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && (|w_grant);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (r_we)
          w_state_nxt = S_RESP;
        else if (w_read_ok)
          w_state_nxt = S_WAIT;
      end
      S_WAIT:  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we     <= 1'b0;
      r_addr   <= 12'd0;
      r_wdata  <= 8'd0;
      r_idx    <= 2'd0;
      r_rdata  <= 8'd0;
      r_err    <= 1'b0;
      r_rr_ptr <= 2'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_idx   <= w_sel_idx;
        r_rdata <= 8'd0;
        r_err   <= 1'b0;
      end
      // An unclaimed chip ID leaves rdata_vld low: report it as an error.
      if (r_state == S_WAIT) begin
        r_rdata <= i_dbg_rdata_vld ? i_dbg_rdata : 8'd0;
        r_err   <= !i_dbg_rdata_vld;
      end
      if (r_state == S_RESP)
        r_rr_ptr <= r_idx;
    end
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_req_rdy   = ((r_state == S_IDLE) && i_rst_n) ? w_grant : '0;
    o_dbg_addr  = o_busy ? r_addr : 12'd0;
    o_dbg_wdata = o_busy ? r_wdata : 8'd0;
    o_dbg_wen   = (r_state == S_ISSUE) && r_we;
    o_dbg_ren   = (r_state == S_ISSUE) && !r_we && w_read_ok;
    o_rsp_rdata = (r_state == S_RESP) ? r_rdata : 8'd0;
    o_rsp_err   = (r_state == S_RESP) && r_err;
    o_rsp_vld   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      o_rsp_vld[i] = (r_state == S_RESP) && (r_idx == 2'(i));
  end

endmodule

// File: tb/tb_i4001_dbg_arbiter.sv
// Bench for i4001_dbg_arbiter: vector table plus hand sequences, a ROM model and a response scoreboard.
module tb_i4001_dbg_arbiter;
  localparam int N = 3;

  logic              clk;
  logic              rst_n;
  logic              sync;
  logic [N-1:0]      req_vld;
  logic [N-1:0]      req_we;
  logic [N-1:0][11:0] req_addr;
  logic [N-1:0][7:0] req_wdata;
  logic [N-1:0]      req_rdy;
  logic [N-1:0]      rsp_vld;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [11:0]       dbg_addr;
  logic [7:0]        dbg_wdata;
  logic              dbg_wen;
  logic              dbg_ren;
  logic [7:0]        dbg_rdata;
  logic              dbg_rdata_vld;

  i4001_dbg_arbiter #(.NUM_REQ(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sync(sync),
    .i_req_vld(req_vld), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_rdy(req_rdy), .o_rsp_vld(rsp_vld), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_busy(busy), .o_dbg_addr(dbg_addr), .o_dbg_wdata(dbg_wdata),
    .o_dbg_wen(dbg_wen), .o_dbg_ren(dbg_ren),
    .i_dbg_rdata(dbg_rdata), .i_dbg_rdata_vld(dbg_rdata_vld)
  );

  typedef struct {
    int         idx;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  typedef struct {
    int          idx;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          sync_ph = 0;
  bit          sync_en = 0;
  logic [7:0]  mem [0:4095];
  int          wen_cnt = 0, ren_cnt = 0, rsp_cnt = 0;
  int          last_wen_cyc = 0, last_ren_cyc = 0, last_ren_ph = 0;
  logic [11:0] last_wen_addr = '0;
  logic [7:0]  last_wen_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MCS-4 sync: high for the cycle in which sync_ph is 7, so DUT phase tracks sync_ph.
  initial begin
    sync = 1'b0;
    forever begin
      @(posedge clk);
      sync_ph <= (sync_ph + 1) % 8;
      #1;
      sync = sync_en && (sync_ph == 7);
    end
  end

  // ROM model: chips 0..3 exist; read data is returned in the cycle after dbg_ren.
  initial begin : rom
    logic        rs;
    logic [11:0] ra;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h5C;
    mem[12'h3FF] = 8'h77;
    dbg_rdata     = 8'h00;
    dbg_rdata_vld = 1'b0;
    forever begin
      @(negedge clk);
      rs = dbg_ren;
      ra = dbg_addr;
      if (dbg_wen) mem[dbg_addr] = dbg_wdata;
      @(posedge clk);
      #1;
      if (rs && (ra[11:8] < 4'd4)) begin
        dbg_rdata_vld = 1'b1;
        dbg_rdata     = mem[ra];
      end else begin
        dbg_rdata_vld = 1'b0;
        dbg_rdata     = 8'h00;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (dbg_wen) begin
        wen_cnt++;
        last_wen_cyc  = cyc;
        last_wen_addr = dbg_addr;
        last_wen_data = dbg_wdata;
      end
      if (dbg_ren) begin
        ren_cnt++;
        last_ren_cyc = cyc;
        last_ren_ph  = sync_ph;
      end
      if (dbg_wen && dbg_ren) begin
        n_fail++;
        $display("FAIL wen_ren_both: got wen=1 ren=1 expected at most one");
      end
      if (!busy) check("idle_addr", {20'd0, dbg_addr}, 32'd0);
      if (|rsp_vld) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rsp_vld=%b expected none", rsp_vld);
        end else begin
          e = sb.pop_front();
          check("rsp_vld", {29'd0, rsp_vld}, 32'd1 << e.idx);
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic do_req(input int idx, input logic we, input logic [11:0] addr,
                        input logic [7:0] wd, input logic [7:0] er, input logic ee,
                        input int stall, output int acc);
    int lat;
    acc = -1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wd;
    req_vld[idx]   = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_rdy[idx]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL grant_timeout: got no req_rdy for req%0d expected a grant", idx);
    end else begin
      check("grant_onehot", {29'd0, req_rdy}, 32'd1 << idx);
      lat = we ? 2 : 3 + stall;
      sb.push_back('{idx: idx, rdata: er, err: ee, cyc: acc + lat});
    end
    @(posedge clk);
    #1;
    req_vld[idx] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d responses pending expected 0", name, sb.size());
      sb.delete();
    end
    #1;
  endtask

  vec_t vt[8];
  int   acc, w0, r0, k, rc;
  int   start_ph[3] = '{1, 2, 5};
  int   exp_stall[3] = '{2, 1, 0};
  int   exp_ren_ph[3] = '{4, 4, 6};

  initial begin
    vt[0] = '{0, 1'b1, 12'h123, 8'hA5, 8'h00, 1'b0};
    vt[1] = '{0, 1'b0, 12'h123, 8'h00, 8'hA5, 1'b0};
    vt[2] = '{1, 1'b0, 12'hF00, 8'h00, 8'h00, 1'b1};
    vt[3] = '{2, 1'b1, 12'h3A0, 8'h3C, 8'h00, 1'b0};
    vt[4] = '{2, 1'b0, 12'h3A0, 8'h00, 8'h3C, 1'b0};
    vt[5] = '{1, 1'b0, 12'h500, 8'h00, 8'h00, 1'b1};
    vt[6] = '{1, 1'b1, 12'hF01, 8'h99, 8'h00, 1'b0};
    vt[7] = '{0, 1'b0, 12'h010, 8'h00, 8'h5C, 1'b0};

    // Reset: outputs all zero even with every request pending.
    rst_n     = 1'b0;
    req_vld   = '1;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", {29'd0, req_rdy}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_vld", {29'd0, rsp_vld}, 32'd0);
    check("rst_wen_ren", {30'd0, dbg_wen, dbg_ren}, 32'd0);
    req_vld = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round robin with all three holding write requests.
    for (int i = 0; i < N; i++) begin
      req_we[i]    = 1'b1;
      req_addr[i]  = 12'h200 + 12'(i);
      req_wdata[i] = 8'h30 + 8'(i);
    end
    req_vld = '1;
    k = 0;
    for (int n = 0; n < 60 && k < 6; n++) begin
      @(negedge clk);
      if (|req_rdy) begin
        check("rr_grant", {29'd0, req_rdy}, 32'd1 << (k % 3));
        sb.push_back('{idx: k % 3, rdata: 8'h00, err: 1'b0, cyc: cyc + 2});
        k++;
      end
    end
    if (k < 6) begin
      n_chk++;
      n_fail++;
      $display("FAIL rr_timeout: got %0d grants expected 6", k);
    end
    @(posedge clk);
    #1;
    req_vld = '0;
    drain("rr");

    // Vector table, CPU not running so reads never stall.
    for (int t = 0; t < 8; t++) begin
      w0 = wen_cnt;
      r0 = ren_cnt;
      do_req(vt[t].idx, vt[t].we, vt[t].addr, vt[t].wdata, vt[t].exp_rdata, vt[t].exp_err, 0, acc);
      drain("vec");
      if (acc >= 0) begin
        if (vt[t].we) begin
          check("wen_count", wen_cnt - w0, 1);
          check("wen_addr", {20'd0, last_wen_addr}, {20'd0, vt[t].addr});
          check("wen_data", {24'd0, last_wen_data}, {24'd0, vt[t].wdata});
          check("wen_cycle", last_wen_cyc, acc + 1);
          check("wen_no_ren", ren_cnt - r0, 0);
        end else begin
          check("ren_count", ren_cnt - r0, 1);
          check("ren_cycle", last_ren_cyc, acc + 1);
        end
      end
    end

    // Slot guard: acceptance in A2 lands ISSUE in A3, stalling through M1.
    sync_en = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 10 && sync_ph != start_ph[s]; n++) begin
        @(posedge clk);
        #1;
      end
      r0 = ren_cnt;
      do_req(1, 1'b0, 12'h010, 8'h00, 8'h5C, 1'b0, exp_stall[s], acc);
      drain("slot");
      if (acc >= 0) begin
        check("slot_ren_count", ren_cnt - r0, 1);
        check("slot_ren_phase", last_ren_ph, exp_ren_ph[s]);
        check("slot_ren_cycle", last_ren_cyc, acc + 1 + exp_stall[s]);
      end
    end

    // CPU stopped: no sync for 20 cycles, read goes out immediately.
    sync_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    r0 = ren_cnt;
    do_req(2, 1'b0, 12'h3FF, 8'h00, 8'h77, 1'b0, 0, acc);
    drain("stopped");
    if (acc >= 0) check("stopped_ren_cycle", last_ren_cyc, acc + 1);

    // Reset while the read sits in WAIT.
    req_we[1]   = 1'b0;
    req_addr[1] = 12'h123;
    req_vld[1]  = 1'b1;
    acc = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_rdy[1]) begin
        acc = n;
        break;
      end
    end
    check("mid_grant", acc >= 0 ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_vld[1] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rc = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_addr", {20'd0, dbg_addr}, 32'd0);
    check("mid_rst_wen_ren", {30'd0, dbg_wen, dbg_ren}, 32'd0);
    check("mid_rst_rsp", {20'd0, rsp_vld, rsp_err, rsp_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_no_rsp", rsp_cnt - rc, 0);
    req_we  = '1;
    req_vld = '1;
    @(negedge clk);
    check("post_rst_grant", {29'd0, req_rdy}, 32'd1);
    if (req_rdy[0]) sb.push_back('{idx: 0, rdata: 8'h00, err: 1'b0, cyc: cyc + 2});
    @(posedge clk);
    #1;
    req_vld = '0;
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
